// File: rtl/seg_scan_display_pkg.sv
// Shared seven-segment constants and the nibble-to-segment lookup used by the
// scanning display controller.
package seg_pkg;

    localparam logic [6:0] SEG_HEX_0 = 7'h3F;
    localparam logic [6:0] SEG_HEX_1 = 7'h06;
    localparam logic [6:0] SEG_HEX_2 = 7'h5B;
    localparam logic [6:0] SEG_HEX_3 = 7'h4F;
    localparam logic [6:0] SEG_HEX_4 = 7'h66;
    localparam logic [6:0] SEG_HEX_5 = 7'h6D;
    localparam logic [6:0] SEG_HEX_6 = 7'h7D;
    localparam logic [6:0] SEG_HEX_7 = 7'h07;
    localparam logic [6:0] SEG_HEX_8 = 7'h7F;
    localparam logic [6:0] SEG_HEX_9 = 7'h6F;
    localparam logic [6:0] SEG_HEX_A = 7'h77;
    localparam logic [6:0] SEG_HEX_B = 7'h7C;
    localparam logic [6:0] SEG_HEX_C = 7'h58;
    localparam logic [6:0] SEG_HEX_D = 7'h5E;
    localparam logic [6:0] SEG_HEX_E = 7'h40;  // E is rendered as a dash
    localparam logic [6:0] SEG_HEX_F = 7'h71;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    function automatic logic [6:0] seg_hex(input logic [3:0] nibble);
        case (nibble)
            4'h0: seg_hex = SEG_HEX_0;
            4'h1: seg_hex = SEG_HEX_1;
            4'h2: seg_hex = SEG_HEX_2;
            4'h3: seg_hex = SEG_HEX_3;
            4'h4: seg_hex = SEG_HEX_4;
            4'h5: seg_hex = SEG_HEX_5;
            4'h6: seg_hex = SEG_HEX_6;
            4'h7: seg_hex = SEG_HEX_7;
            4'h8: seg_hex = SEG_HEX_8;
            4'h9: seg_hex = SEG_HEX_9;
            4'hA: seg_hex = SEG_HEX_A;
            4'hB: seg_hex = SEG_HEX_B;
            4'hC: seg_hex = SEG_HEX_C;
            4'hD: seg_hex = SEG_HEX_D;
            4'hE: seg_hex = SEG_HEX_E;
            default: seg_hex = SEG_HEX_F;
        endcase
    endfunction

endpackage

// File: rtl/seg_scan_display_decoder.sv
// Combinational single-digit decoder: hex nibble plus decimal point to an
// active-high 8-bit segment pattern (bit 7 = dp).
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       dp_i,
    output logic [7:0] seg_o
);

    assign seg_o = {dp_i, seg_hex(nibble_i)};

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment scanner with staging/shadow frame buffering,
// per-digit blanking, decimal points and leading-zero suppression.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int SCAN_DIV      = 50000,
    parameter bit AN_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    en_i,
    input  logic [4*NUM_DIGITS-1:0] data_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [NUM_DIGITS-1:0]   blank_i,
    input  logic                    lz_i,
    input  logic                    load_i,
    output logic [7:0]              seg_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    frame_o
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{AN_ACTIVE_LOW}};

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] stg_data_q, stg_data_d, shd_data_q, shd_data_d;
    logic [NUM_DIGITS-1:0]   stg_dp_q, stg_dp_d, shd_dp_q, shd_dp_d;
    logic [NUM_DIGITS-1:0]   stg_blank_q, stg_blank_d, shd_blank_q, shd_blank_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_q, frame_d;

    logic                    tick, wrap;
    logic [3:0]              shd_nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   lz_sup;
    logic [3:0]              cur_nib;
    logic [7:0]              dec_seg;

    // Scan timing and frame buffering
    always_comb begin
        tick        = en_i && (cnt_q == CNT_LAST);
        wrap        = tick && (idx_q == IDX_LAST);
        cnt_d       = tick ? '0 : cnt_q + 1'b1;
        idx_d       = idx_q;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end
        if (!en_i) begin
            cnt_d = '0;
            idx_d = '0;
        end
        stg_data_d  = load_i ? data_i  : stg_data_q;
        stg_dp_d    = load_i ? dp_i    : stg_dp_q;
        stg_blank_d = load_i ? blank_i : stg_blank_q;
        // The shadow takes the pre-load staging value, so a load on the wrap
        // edge waits a full frame.
        shd_data_d  = wrap ? stg_data_q  : shd_data_q;
        shd_dp_d    = wrap ? stg_dp_q    : shd_dp_q;
        shd_blank_d = wrap ? stg_blank_q : shd_blank_q;
    end

    // Leading-zero mask: prefix-OR of nonzero nibbles from the MSB downward
    always_comb begin
        logic nz;
        nz = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            shd_nib[k] = shd_data_q[4*k +: 4];
            nz         = nz | (|shd_data_q[4*k +: 4]);
            lz_sup[k]  = lz_i && !nz && (k != 0);
        end
    end

    assign cur_nib = shd_nib[idx_q];

    seg_hex_decoder u_dec (
        .nibble_i (cur_nib),
        .dp_i     (shd_dp_q[idx_q]),
        .seg_o    (dec_seg)
    );

    // Output stage: one cycle behind idx/shadow
    always_comb begin
        seg_d   = dec_seg;
        an_d    = (NUM_DIGITS'(1) << idx_q) ^ AN_OFF;
        frame_d = en_i && (idx_q == '0) && (cnt_q == '0);
        if (shd_blank_q[idx_q]) begin
            seg_d = SEG_BLANK;
        end else if (lz_sup[idx_q]) begin
            seg_d = {shd_dp_q[idx_q], 7'h00};
        end
        if (!en_i) begin
            seg_d = SEG_BLANK;
            an_d  = AN_OFF;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            stg_data_q  <= '0;
            stg_dp_q    <= '0;
            stg_blank_q <= '0;
            shd_data_q  <= '0;
            shd_dp_q    <= '0;
            shd_blank_q <= '0;
            seg_q       <= SEG_BLANK;
            an_q        <= AN_OFF;
            frame_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            stg_data_q  <= stg_data_d;
            stg_dp_q    <= stg_dp_d;
            stg_blank_q <= stg_blank_d;
            shd_data_q  <= shd_data_d;
            shd_dp_q    <= shd_dp_d;
            shd_blank_q <= shd_blank_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            frame_q     <= frame_d;
        end
    end

    assign seg_o   = seg_q;
    assign an_o    = an_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: frame-position reference model checked every
// cycle, plus literal checks of the scan order, decoding and buffering cases.
module tb_seg_scan_display;

    localparam int N  = 4;
    localparam int S  = 4;
    localparam int NS = N * S;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic [4*N-1:0] data;
    logic [N-1:0]   dp;
    logic [N-1:0]   blank;
    logic           lz;
    logic           load;
    logic [7:0]     seg_o;
    logic [N-1:0]   an_o;
    logic           frame_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seg_scan_display #(
        .NUM_DIGITS    (N),
        .SCAN_DIV      (S),
        .AN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .en_i    (en),
        .data_i  (data),
        .dp_i    (dp),
        .blank_i (blank),
        .lz_i    (lz),
        .load_i  (load),
        .seg_o   (seg_o),
        .an_o    (an_o),
        .frame_o (frame_o)
    );

    logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h40, 7'h71};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // What digit k must show, from the display rules alone
    function automatic logic [7:0] exp_seg(input logic [4*N-1:0] d, input logic [N-1:0] p,
                                           input logic [N-1:0] b, input logic lzs, input int k);
        bit all_zero;
        all_zero = 1'b1;
        for (int j = k; j < N; j++) begin
            if (d[4*j +: 4] != 4'h0) all_zero = 1'b0;
        end
        if (b[k]) return 8'h00;
        if (lzs && k != 0 && all_zero) return {p[k], 7'h00};
        return {p[k], HEX[d[4*k +: 4]]};
    endfunction

    // Reference model: position in frame is elapsed enabled cycles t
    logic [4*N-1:0] m_stg_data, m_shd_data;
    logic [N-1:0]   m_stg_dp, m_shd_dp, m_stg_bl, m_shd_bl;
    int             m_t;
    logic [7:0]     e_seg;
    logic [N-1:0]   e_an;
    logic           e_frame;
    bit             m_valid = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_stg_data <= '0; m_stg_dp <= '0; m_stg_bl <= '0;
            m_shd_data <= '0; m_shd_dp <= '0; m_shd_bl <= '0;
            m_t <= 0;
            e_seg <= 8'h00; e_an <= '1; e_frame <= 1'b0;
        end else begin
            if (en) begin
                e_seg   <= exp_seg(m_shd_data, m_shd_dp, m_shd_bl, lz, (m_t / S) % N);
                e_an    <= ~(N'(1) << ((m_t / S) % N));
                e_frame <= (m_t % NS) == 0;
                if (m_t % NS == NS - 1) begin
                    m_shd_data <= m_stg_data; m_shd_dp <= m_stg_dp; m_shd_bl <= m_stg_bl;
                end
                m_t <= m_t + 1;
            end else begin
                e_seg <= 8'h00; e_an <= '1; e_frame <= 1'b0;
                m_t <= 0;
            end
            if (load) begin
                m_stg_data <= data; m_stg_dp <= dp; m_stg_bl <= blank;
            end
        end
        m_valid <= 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_seg", seg_o, e_seg);
            chk("model_an", an_o, e_an);
            chk("model_frame", frame_o, e_frame);
        end
    end

    logic [7:0] cap [N];

    task automatic wait_an(input logic [N-1:0] val, input string what);
        int n = 0;
        while (an_o !== val && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk(what, an_o, val);
    endtask

    task automatic cap_frame(input string what);
        int n = 0;
        while (frame_o !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk(what, frame_o, 1'b1);
        for (int k = 0; k < N; k++) begin
            cap[k] = seg_o;
            if (k < N - 1) repeat (S) @(negedge clk);
        end
    endtask

    task automatic pulse_load(input logic [4*N-1:0] d, input logic [N-1:0] p, input logic [N-1:0] b);
        data = d; dp = p; blank = b; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    logic [N-1:0] AN_SEQ [N] = '{4'hE, 4'hD, 4'hB, 4'h7};

    initial begin
        rst_n = 1'b0; en = 1'b1; data = '0; dp = '0; blank = '0; lz = 1'b0; load = 1'b0;

        // Reset state
        repeat (3) begin
            @(negedge clk);
            chk("reset_seg", seg_o, 8'h00);
            chk("reset_an", an_o, 4'hF);
            chk("reset_frame", frame_o, 1'b0);
        end
        rst_n = 1'b1;

        // Scan order after release: E x4, D x4, B x4, 7 x4, E
        for (int i = 0; i <= NS; i++) begin
            @(negedge clk);
            chk("scan_an", an_o, AN_SEQ[(i / S) % N]);
            chk("scan_frame", frame_o, (i % NS) == 0);
        end

        // Decode sweep, dp alternating
        for (int v = 0; v < 16; v++) begin
            logic [3:0] nv;
            nv = v[3:0];
            pulse_load({N{nv}}, v[0] ? 4'b1010 : 4'b0101, 4'b0000);
            repeat (2 * NS) @(negedge clk);
        end

        // Tear-free load while digit 2 is selected
        wait_an(4'hB, "wait_d2");
        pulse_load(16'h1234, 4'b0000, 4'b0000);
        cap_frame("tf_frame");
        chk("tf_d0", cap[0], 8'h66);
        chk("tf_d1", cap[1], 8'h4F);
        chk("tf_d2", cap[2], 8'h5B);
        chk("tf_d3", cap[3], 8'h06);

        // Load on the wrap tick: shown one frame later
        wait_an(4'hB, "wait_d2b");
        wait_an(4'h7, "wait_d3");
        repeat (S - 2) @(negedge clk);
        pulse_load(16'hABCD, 4'b0000, 4'b0000);
        cap_frame("wrap_frame1");
        chk("wrap_old_d0", cap[0], 8'h66);
        cap_frame("wrap_frame2");
        chk("wrap_d0", cap[0], 8'h5E);
        chk("wrap_d1", cap[1], 8'h58);
        chk("wrap_d2", cap[2], 8'h7C);
        chk("wrap_d3", cap[3], 8'h77);

        // Leading-zero suppression
        lz = 1'b1;
        pulse_load(16'h0050, 4'b1000, 4'b0000);
        cap_frame("lz_f1");
        cap_frame("lz_f2");
        chk("lz_d0", cap[0], 8'h3F);
        chk("lz_d1", cap[1], 8'h6D);
        chk("lz_d2", cap[2], 8'h00);
        chk("lz_d3", cap[3], 8'h80);
        pulse_load(16'h0000, 4'b0000, 4'b0000);
        cap_frame("lz0_f1");
        cap_frame("lz0_f2");
        chk("lz0_d0", cap[0], 8'h3F);
        chk("lz0_d1", cap[1], 8'h00);
        chk("lz0_d2", cap[2], 8'h00);
        chk("lz0_d3", cap[3], 8'h00);
        lz = 1'b0;

        // Blank has priority over dp
        pulse_load(16'h1234, 4'b0010, 4'b0010);
        cap_frame("bl_f1");
        cap_frame("bl_f2");
        chk("blank_d0", cap[0], 8'h66);
        chk("blank_d1", cap[1], 8'h00);

        // Enable dropped mid-frame, then re-raised
        wait_an(4'hB, "wait_en");
        en = 1'b0;
        @(negedge clk);
        chk("en_off_seg", seg_o, 8'h00);
        chk("en_off_an", an_o, 4'hF);
        chk("en_off_frame", frame_o, 1'b0);
        en = 1'b1;
        @(negedge clk);
        chk("en_on_an", an_o, 4'hE);
        chk("en_on_frame", frame_o, 1'b1);
        chk("en_on_seg", seg_o, 8'h66);

        // Reset mid-frame clears the shadow
        wait_an(4'hB, "wait_rst");
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_an", an_o, 4'hF);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rel_an", an_o, 4'hE);
        chk("rst_rel_frame", frame_o, 1'b1);
        chk("rst_rel_seg", seg_o, 8'h3F);

        // Randomised traffic checked by the model
        for (int c = 0; c < 3000; c++) begin
            load  = ($urandom % 6) == 0;
            data  = ($urandom % 3 == 0) ? 16'($urandom & 32'h00FF) : 16'($urandom);
            dp    = 4'($urandom);
            blank = 4'($urandom & $urandom & $urandom);
            if ($urandom % 40 == 0) lz = ~lz;
            if (en) begin
                if ($urandom % 80 == 0) en = 1'b0;
            end else if ($urandom % 4 == 0) begin
                en = 1'b1;
            end
            rst_n = ($urandom % 500) != 0;
            @(negedge clk);
        end
        load = 1'b0; rst_n = 1'b1;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_display.md
# seg_scan_display

Multiplexed multi-digit seven-segment display controller: holds a frame of NUM_DIGITS hex nibbles, decodes one digit at a time to segment patterns and drives a one-hot digit-select bus, cycling through all digits at a programmable scan rate. It sits between the datapath, which presents packed nibbles plus per-digit decimal-point and blank masks, and the board's shared segment/anode pins. It extends the single-digit decoder with scanning, tear-free frame buffering, per-digit blanking, decimal point and leading-zero suppression.

## Interface
- NUM_DIGITS, 8: digits driven; legal range 2..16.
- SCAN_DIV, 50000: clock cycles each digit stays selected; minimum 2.
- AN_ACTIVE_LOW, 1: 1 means the selected digit's an_o bit is 0 and all others are 1; 0 inverts this.
- clk_i  in  1  single clock; all state changes on its rising edge.
- rst_n_i  in  1  synchronous, active-low reset.
- en_i  in  1  1 = display on; 0 = display blanked and scan held in reset state.
- data_i  in  4*NUM_DIGITS  packed nibbles; digit k is data_i[4k+3:4k]; digit NUM_DIGITS-1 is most significant.
- dp_i  in  NUM_DIGITS  per-digit decimal point.
- blank_i  in  NUM_DIGITS  per-digit force-blank.
- lz_i  in  1  leading-zero suppression enable.
- load_i  in  1  one-cycle strobe; captures data_i/dp_i/blank_i into staging.
- seg_o  out  8  segments; bit 7 = dp, bits 6..0 = g..a; active high.
- an_o  out  NUM_DIGITS  digit select, polarity per AN_ACTIVE_LOW.
- frame_o  out  1  one-cycle pulse when a new frame starts (digit 0 selected).

## Operation
- Hex codes (bits 6..0): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=58 d=5E E=40 (dash) F=71.
- Prescaler cnt counts 0..SCAN_DIV-1. tick = (cnt==SCAN_DIV-1) & en_i; cnt wraps to 0 on tick.
- Digit index idx is $clog2(NUM_DIGITS) bits wide and increments on tick, wrapping from NUM_DIGITS-1 to 0; it never takes values >= NUM_DIGITS.
- Buffering: load_i captures all three inputs into staging. The shadow copy is what gets displayed. Staging is copied into shadow on the wrap tick (idx NUM_DIGITS-1 -> 0). A load in the same cycle as the wrap tick lands in staging only and is displayed from the following frame.
- Per-digit value from shadow, in priority order:
  - blank_k=1: seg 00, including dp.
  - Leading-zero suppression: lz_i=1, nibble k=0, all more-significant nibbles 0, and k!=0. Seg 7 bits are 0; dp still shown.
  - Otherwise: hex code with bit 7 = dp_k.
  - lz_i is sampled live, not buffered.
- en_i=0: cnt<=0, idx<=0, seg_o<=00, an_o all inactive, frame_o<=0. Staging and shadow still load normally.

## Timing
- Reset (rst_n_i=0 at an edge): cnt=0, idx=0, staging and shadow all zero, seg_o=00, an_o all inactive, frame_o=0.
- seg_o, an_o and frame_o are registered and reflect idx/shadow with one cycle of latency. They update at the edge after any idx change.
- frame_o is asserted for exactly the one cycle in which an_o first selects digit 0 of a new frame.
- After release from reset or en_i going 0 -> 1, digit 0 is driven on the next cycle and held SCAN_DIV cycles.
- Digit dwell is exactly SCAN_DIV cycles; frame period is NUM_DIGITS*SCAN_DIV cycles.
- Reset mid-frame takes effect at that edge; pending staging data is discarded.

## Structure
- Package seg_pkg: 16 hex segment constants, SEG_BLANK=8'h00, and a function seg_hex(nibble)->7 bits.
- Sub-module seg_hex_decoder (combinational nibble + dp -> 8-bit pattern) instantiated once on the muxed digit.
- Leading-zero mask: one combinational prefix-OR over the shadow nibbles from the MSB down.

## Test plan
- Reset/idle: rst_n_i=0 for 3 cycles, then en_i=1, NUM_DIGITS=4, SCAN_DIV=4 -> seg_o=00 and an_o=F during reset; after release, an_o=E held 4 cycles, then D, B, 7, E; frame_o pulses coincide with each an_o=E entry.
- Decode sweep: load nibbles 0..F over successive frames, dp_i alternating -> seg_o matches the code list, with bit 7 following dp.
- Tear-free load: pulse load_i with data 16'h1234 while digit 2 is selected -> the current frame still shows the old data; the next frame shows 4,3,2,1 on digits 0..3. Repeat with load_i on the wrap-tick cycle -> the new data appears one frame later.
- Leading zeros: data 16'h0050, lz_i=1, dp_i=4'b1000 -> digit 3 seg=80, digit 2 seg=00, digit 1=6D, digit 0=3F. Data 0000 -> only digit 0 shows 3F.
- Blank priority: blank_i=4'b0010, dp_i=4'b0010 -> digit 1 seg=00.
- Enable/reset mid-frame: drop en_i while digit 2 is selected -> the next cycle has seg_o=00, an_o=F. Re-raise en_i -> digit 0 is shown with a frame_o pulse. Assert rst_n_i mid-frame -> shadow is cleared.
